// File: rtl/mul_seq.sv
// Multi-cycle shift-add multiplier that borrows the shared ALU for one add per step.
// Define MUL_SEQ_SIGNED_EN to add signed (mult) support through magnitude loading and a final negate.
module mul_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             alu_req,
    input  logic             alu_gnt,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_cout
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);
    localparam logic [3:0] ALU_ADD = 4'b0010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
`ifdef MUL_SEQ_SIGNED_EN
        FIX  = 2'd3,
`endif
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] mc_q, mc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             neg_pending;

`ifdef MUL_SEQ_SIGNED_EN
    logic             neg_q, neg_d;
    logic             a_neg, b_neg;
    logic [2*WIDTH-1:0] prod_neg;

    always_comb begin
        a_neg       = is_signed & src_a[WIDTH-1];
        b_neg       = is_signed & src_b[WIDTH-1];
        a_mag       = a_neg ? (~src_a + 1'b1) : src_a;
        b_mag       = b_neg ? (~src_b + 1'b1) : src_b;
        prod_neg    = ~{hi_q, lo_q} + 1'b1;
        neg_pending = neg_q;
    end
`else
    logic unused_is_signed;

    always_comb begin
        unused_is_signed = is_signed;
        a_mag            = src_a;
        b_mag            = src_b;
        neg_pending      = 1'b0;
    end
`endif

    always_comb begin
        state_d  = state_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        mc_d     = mc_q;
        cnt_d    = cnt_q;
`ifdef MUL_SEQ_SIGNED_EN
        neg_d    = neg_q;
`endif
        alu_req  = 1'b0;
        alu_a    = '0;
        alu_b    = '0;
        alu_ctrl = 4'b0000;

        case (state_q)
            IDLE, DONE: begin
                if (state_q == DONE) begin
                    state_d = IDLE;
                end
                if (start) begin
                    state_d = RUN;
                    hi_d    = '0;
                    lo_d    = b_mag;
                    mc_d    = a_mag;
                    cnt_d   = '0;
`ifdef MUL_SEQ_SIGNED_EN
                    neg_d   = a_neg ^ b_neg;
`endif
                end
            end
            RUN: begin
                alu_req  = 1'b1;
                alu_ctrl = ALU_ADD;
                alu_a    = hi_q;
                alu_b    = lo_q[0] ? mc_q : '0;
                // The WIDTH+1-bit {carry, sum} becomes the new top of {HI,LO}.
                if (alu_gnt) begin
                    {hi_d, lo_d} = {alu_cout, alu_result, lo_q[WIDTH-1:1]};
                    cnt_d        = cnt_q + 1'b1;
                    if (cnt_q == LAST_STEP) begin
`ifdef MUL_SEQ_SIGNED_EN
                        state_d = neg_pending ? FIX : DONE;
`else
                        state_d = neg_pending ? IDLE : DONE;
`endif
                    end
                end
            end
`ifdef MUL_SEQ_SIGNED_EN
            FIX: begin
                {hi_d, lo_d} = prod_neg;
                neg_d        = 1'b0;
                state_d      = DONE;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            mc_q    <= '0;
            cnt_q   <= '0;
`ifdef MUL_SEQ_SIGNED_EN
            neg_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            mc_q    <= mc_d;
            cnt_q   <= cnt_d;
`ifdef MUL_SEQ_SIGNED_EN
            neg_q   <= neg_d;
`endif
        end
    end

`ifdef MUL_SEQ_SIGNED_EN
    assign busy = (state_q == RUN) || (state_q == FIX);
`else
    assign busy = (state_q == RUN);
`endif
    assign done = (state_q == DONE);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mul_seq.sv
// Directed self-checking bench for mul_seq, with a behavioural ALU adder in the loop.
module tb_mul_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        is_signed;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        alu_req;
    logic        alu_gnt;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_result;
    logic        alu_cout;

    int n_pass;
    int n_total;

    mul_seq #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .is_signed  (is_signed),
        .src_a      (src_a),
        .src_b      (src_b),
        .busy       (busy),
        .done       (done),
        .hi         (hi),
        .lo         (lo),
        .alu_req    (alu_req),
        .alu_gnt    (alu_gnt),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result),
        .alu_cout   (alu_cout)
    );

    assign {alu_cout, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Assumes start was sampled at the previous edge and we sit #1 after it (cycle 1).
    task automatic wait_done(input bit toggle, output int cyc, output logic busy_at);
        cyc = 1;
        alu_gnt = toggle ? 1'b0 : 1'b1;
        while (done !== 1'b1 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            alu_gnt = toggle ? ((cyc % 2) == 0) : 1'b1;
        end
        busy_at = busy;
        alu_gnt = 1'b1;
    endtask

    task automatic do_mul(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                          input bit toggle, output int cyc, output logic busy_at);
        @(negedge clk);
        start = 1'b1; src_a = a; src_b = b; is_signed = sgn;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(toggle, cyc, busy_at);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; is_signed = 1'b0;
        src_a = '0; src_b = '0; alu_gnt = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_total++; if ({busy, done, alu_req} !== 3'b000) $display("FAIL reset_ctrl got %b want 000", {busy, done, alu_req}); else n_pass++;
        n_total++; if ({hi, lo} !== 64'h0) $display("FAIL reset_prod got %h want 0", {hi, lo}); else n_pass++;
        n_total++; if ({alu_a, alu_b, alu_ctrl} !== 68'h0) $display("FAIL reset_alu got %h want 0", {alu_a, alu_b, alu_ctrl}); else n_pass++;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        n_total++; if ({busy, done, alu_req} !== 3'b000) $display("FAIL idle_ctrl got %b want 000", {busy, done, alu_req}); else n_pass++;
    endtask

    task automatic test_alu_if;
        int cyc;
        logic b_at;
        @(negedge clk);
        start = 1'b1; src_a = 32'd3; src_b = 32'd5; is_signed = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        n_total++; if ({busy, alu_req, alu_ctrl} !== 6'b11_0010) $display("FAIL run_ctrl got %b want 110010", {busy, alu_req, alu_ctrl}); else n_pass++;
        n_total++; if ({alu_a, alu_b} !== {32'd0, 32'd3}) $display("FAIL step1_ops got %h want %h", {alu_a, alu_b}, {32'd0, 32'd3}); else n_pass++;
        @(posedge clk); #1;
        n_total++; if ({alu_a, alu_b, lo} !== {32'd1, 32'd0, 32'h80000002}) $display("FAIL step2_ops got %h want %h", {alu_a, alu_b, lo}, {32'd1, 32'd0, 32'h80000002}); else n_pass++;
        alu_gnt = 1'b0;
        @(posedge clk); #1;
        n_total++; if ({alu_req, alu_a, alu_b, lo} !== {1'b1, 32'd1, 32'd0, 32'h80000002}) $display("FAIL stall_hold got %h want %h", {alu_req, alu_a, alu_b, lo}, {1'b1, 32'd1, 32'd0, 32'h80000002}); else n_pass++;
        wait_done(1'b0, cyc, b_at);
        n_total++; if (cyc + 2 !== 34) $display("FAIL stall_latency got %0d want 34", cyc + 2); else n_pass++;
        n_total++; if ({hi, lo} !== 64'hF) $display("FAIL stall_prod got %h want f", {hi, lo}); else n_pass++;
    endtask

    task automatic test_basic;
        int cyc;
        logic b_at;
        do_mul(32'd3, 32'd5, 1'b0, 1'b0, cyc, b_at);
        n_total++; if (cyc !== 33) $display("FAIL basic_latency got %0d want 33", cyc); else n_pass++;
        n_total++; if (b_at !== 1'b0) $display("FAIL basic_busy_at_done got %b want 0", b_at); else n_pass++;
        n_total++; if ({hi, lo} !== 64'h0000_0000_0000_000F) $display("FAIL basic_prod got %h want f", {hi, lo}); else n_pass++;
        n_total++; if ({alu_req, alu_ctrl} !== 5'b0) $display("FAIL done_alu got %b want 0", {alu_req, alu_ctrl}); else n_pass++;
    endtask

    task automatic test_all_ones;
        int cyc;
        logic b_at;
        do_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, cyc, b_at);
        n_total++; if ({hi, lo} !== 64'hFFFFFFFE_00000001) $display("FAIL ones_prod got %h want fffffffe00000001", {hi, lo}); else n_pass++;
        @(posedge clk); #1;
        n_total++; if ({done, busy} !== 2'b00) $display("FAIL done_one_cycle got %b want 00", {done, busy}); else n_pass++;
        repeat (3) @(posedge clk);
        #1;
        n_total++; if ({hi, lo} !== 64'hFFFFFFFE_00000001) $display("FAIL prod_held got %h want fffffffe00000001", {hi, lo}); else n_pass++;
    endtask

    task automatic test_gnt_toggle;
        int cyc;
        logic b_at;
        do_mul(32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b1, cyc, b_at);
        n_total++; if (cyc !== 65) $display("FAIL toggle_latency got %0d want 65", cyc); else n_pass++;
        n_total++; if ({hi, lo} !== 64'h0B00EA4E_242D2080) $display("FAIL toggle_prod got %h want 0b00ea4e242d2080", {hi, lo}); else n_pass++;
    endtask

    task automatic test_start_ignored;
        int cyc;
        int pulses;
        int done_cyc;
        logic [63:0] prod;
        pulses = 0; done_cyc = 0; prod = '0;
        @(negedge clk);
        start = 1'b1; src_a = 32'h00010001; src_b = 32'h00000100; is_signed = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        while (cyc < 60) begin
            if (cyc == 10) begin
                start = 1'b1; src_a = 32'hFFFFFFFF; src_b = 32'hFFFFFFFF;
            end
            if (cyc == 11) start = 1'b0;
            if (done === 1'b1) begin
                pulses++;
                if (pulses == 1) begin
                    done_cyc = cyc;
                    prod = {hi, lo};
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        n_total++; if (pulses !== 1) $display("FAIL ignore_pulses got %0d want 1", pulses); else n_pass++;
        n_total++; if (done_cyc !== 33) $display("FAIL ignore_latency got %0d want 33", done_cyc); else n_pass++;
        n_total++; if (prod !== 64'h00000000_01000100) $display("FAIL ignore_prod got %h want 01000100", prod); else n_pass++;
    endtask

    task automatic test_reset_abort;
        int cyc;
        logic b_at;
        @(negedge clk);
        start = 1'b1; src_a = 32'h12345678; src_b = 32'h9ABCDEF0; is_signed = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        #2;
        n_total++; if ({busy, alu_req} !== 2'b11) $display("FAIL abort_pre got %b want 11", {busy, alu_req}); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_total++; if ({busy, alu_req, done} !== 3'b000) $display("FAIL abort_ctrl got %b want 000", {busy, alu_req, done}); else n_pass++;
        n_total++; if ({hi, lo} !== 64'h0) $display("FAIL abort_prod got %h want 0", {hi, lo}); else n_pass++;
        @(negedge clk); rst_n = 1'b1;
        do_mul(32'd7, 32'd6, 1'b0, 1'b0, cyc, b_at);
        n_total++; if ({hi, lo} !== 64'd42) $display("FAIL after_abort_prod got %h want 2a", {hi, lo}); else n_pass++;
        n_total++; if (cyc !== 33) $display("FAIL after_abort_latency got %0d want 33", cyc); else n_pass++;
    endtask

    task automatic test_back_to_back;
        int cyc;
        logic b_at;
        do_mul(32'd3, 32'd5, 1'b0, 1'b0, cyc, b_at);
        start = 1'b1; src_a = 32'h10; src_b = 32'h10;
        @(posedge clk); #1;
        start = 1'b0;
        n_total++; if ({busy, done} !== 2'b10) $display("FAIL b2b_accept got %b want 10", {busy, done}); else n_pass++;
        wait_done(1'b0, cyc, b_at);
        n_total++; if (cyc !== 33) $display("FAIL b2b_latency got %0d want 33", cyc); else n_pass++;
        n_total++; if ({hi, lo} !== 64'h100) $display("FAIL b2b_prod got %h want 100", {hi, lo}); else n_pass++;
    endtask

    task automatic test_signed;
        int cyc;
        logic b_at;
        do_mul(32'hFFFFFFFD, 32'd5, 1'b1, 1'b0, cyc, b_at);
`ifdef MUL_SEQ_SIGNED_EN
        n_total++; if (cyc !== 34) $display("FAIL signed_latency got %0d want 34", cyc); else n_pass++;
        n_total++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFF1) $display("FAIL signed_prod got %h want fffffffffffffff1", {hi, lo}); else n_pass++;
`else
        n_total++; if (cyc !== 33) $display("FAIL signed_latency got %0d want 33", cyc); else n_pass++;
        n_total++; if ({hi, lo} !== 64'h00000004_FFFFFFF1) $display("FAIL signed_prod got %h want 4fffffff1", {hi, lo}); else n_pass++;
`endif
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        test_reset;
        test_alu_if;
        test_basic;
        test_all_ones;
        test_gnt_toggle;
        test_start_ignored;
        test_reset_abort;
        test_back_to_back;
        test_signed;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
